// File: rtl/axi_lite_sram.sv
// AXI4-lite slave memory: one-entry AW/W holding registers, registered B and R
// channels, byte-strobed writes and a synchronously cleared word array.
module axi_lite_sram #(
    parameter int DATA_BYTEW = 4,
    parameter int ADDR_BYTEW = 2,
    parameter int AXI_ID_W   = 1,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic [AXI_ID_W-1:0]     i_axi_AWID,
    input  logic [8*ADDR_BYTEW-1:0] i_axi_AWADDR,
    input  logic [2:0]              i_axi_AWPROT,
    input  logic                    i_axi_AWVALID,
    output logic                    o_axi_AWREADY,

    input  logic [8*DATA_BYTEW-1:0] i_axi_WDATA,
    input  logic [DATA_BYTEW-1:0]   i_axi_WSTRB,
    input  logic                    i_axi_WVALID,
    output logic                    o_axi_WREADY,

    output logic [AXI_ID_W-1:0]     o_axi_BID,
    output logic [1:0]              o_axi_BRESP,
    output logic                    o_axi_BVALID,
    input  logic                    i_axi_BREADY,

    input  logic [AXI_ID_W-1:0]     i_axi_ARID,
    input  logic [8*ADDR_BYTEW-1:0] i_axi_ARADDR,
    input  logic [2:0]              i_axi_ARPROT,
    input  logic                    i_axi_ARVALID,
    output logic                    o_axi_ARREADY,

    output logic [AXI_ID_W-1:0]     o_axi_RID,
    output logic [8*DATA_BYTEW-1:0] o_axi_RDATA,
    output logic [1:0]              o_axi_RRESP,
    output logic                    o_axi_RVALID,
    input  logic                    i_axi_RREADY
);
    localparam int DW    = 8 * DATA_BYTEW;
    localparam int AW    = 8 * ADDR_BYTEW;
    localparam int LSB   = $clog2(DATA_BYTEW);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0]         r_mem [DEPTH];

    logic                  r_aw_full;
    logic [AW-1:0]         r_aw_addr;
    logic [AXI_ID_W-1:0]   r_aw_id;
    logic                  r_w_full;
    logic [DW-1:0]         r_w_data;
    logic [DATA_BYTEW-1:0] r_w_strb;

    logic                  r_bvalid;
    logic [AXI_ID_W-1:0]   r_bid;
    logic [1:0]            r_bresp;

    logic                  r_rvalid;
    logic [AXI_ID_W-1:0]   r_rid;
    logic [DW-1:0]         r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                  w_unused;

    // PROT carries no meaning for a plain memory.
    assign w_unused = ^{i_axi_AWPROT, i_axi_ARPROT};

    // Readies depend only on registered state, so no input reaches a VALID/READY.
    assign o_axi_AWREADY = !r_aw_full && !r_bvalid;
    assign o_axi_WREADY  = !r_w_full && !r_bvalid;
    assign o_axi_ARREADY = !r_rvalid;

    // Readies may show 1 while in reset, but nothing is captured then.
    assign w_aw_hs  = i_axi_AWVALID && o_axi_AWREADY && !i_rst;
    assign w_w_hs   = i_axi_WVALID && o_axi_WREADY && !i_rst;
    assign w_ar_hs  = i_axi_ARVALID && o_axi_ARREADY && !i_rst;
    assign w_commit = r_aw_full && r_w_full;

    // In range when every address bit above the word index is zero.
    assign w_wr_in_range = (r_aw_addr >> (DEPTH_LOG2 + LSB)) == '0;
    assign w_rd_in_range = (i_axi_ARADDR >> (DEPTH_LOG2 + LSB)) == '0;
    assign w_wr_idx      = r_aw_addr[DEPTH_LOG2+LSB-1:LSB];
    assign w_rd_idx      = i_axi_ARADDR[DEPTH_LOG2+LSB-1:LSB];

    // AW and W holding registers, filled independently, drained together by the commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= i_axi_AWADDR;
                r_aw_id   <= i_axi_AWID;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= i_axi_WDATA;
                r_w_strb <= i_axi_WSTRB;
            end
        end
    end

    // Memory array: cleared on reset, byte-strobed update on an in-range commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_wr_in_range) begin
            for (int b = 0; b < DATA_BYTEW; b++) begin
                if (r_w_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= r_w_data[8*b +: 8];
                end
            end
        end
    end

    // Write response: raised by the commit, held until the B handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bid    <= r_aw_id;
            r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && i_axi_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read response: the array is sampled before any same-edge commit lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rid    <= i_axi_ARID;
            r_rdata  <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
            r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && i_axi_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign o_axi_BVALID = r_bvalid;
    assign o_axi_BID    = r_bid;
    assign o_axi_BRESP  = r_bresp;
    assign o_axi_RVALID = r_rvalid;
    assign o_axi_RID    = r_rid;
    assign o_axi_RDATA  = r_rdata;
    assign o_axi_RRESP  = r_rresp;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: directed scenarios plus random traffic against a word-array model.
module tb_axi_lite_sram;
    logic        clk;
    logic        rst;
    logic        awid;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        arid;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] model [64];
    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_sram #(
        .DATA_BYTEW(4), .ADDR_BYTEW(2), .AXI_ID_W(1), .DEPTH_LOG2(6)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_axi_AWID(awid), .i_axi_AWADDR(awaddr), .i_axi_AWPROT(awprot),
        .i_axi_AWVALID(awvalid), .o_axi_AWREADY(awready),
        .i_axi_WDATA(wdata), .i_axi_WSTRB(wstrb), .i_axi_WVALID(wvalid),
        .o_axi_WREADY(wready),
        .o_axi_BID(bid), .o_axi_BRESP(bresp), .o_axi_BVALID(bvalid),
        .i_axi_BREADY(bready),
        .i_axi_ARID(arid), .i_axi_ARADDR(araddr), .i_axi_ARPROT(arprot),
        .i_axi_ARVALID(arvalid), .o_axi_ARREADY(arready),
        .o_axi_RID(rid), .o_axi_RDATA(rdata), .o_axi_RRESP(rresp),
        .o_axi_RVALID(rvalid), .i_axi_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [15:0] a);
        return a < 16'h0100;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        return in_range(a) ? model[a[7:2]] : 32'h0;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // w_lead > 0: W goes out that many cycles before AW; < 0: AW leads.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic id, input int w_lead, input int bhold);
        int  t_aw;
        int  t_w;
        int  c;
        bit  aw_done;
        bit  w_done;
        bit  aw_hs;
        bit  w_hs;
        logic [1:0] exp_resp;
        t_aw = (w_lead > 0) ? w_lead : 0;
        t_w  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0;
        w_done  = 0;
        c = 0;
        awaddr = a; awid = id; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && c <= 20) begin
            if (c == t_aw) awvalid = 1'b1;
            if (c == t_w)  wvalid  = 1'b1;
            if (w_done && !aw_done) begin
                chk("w_held_wready", wready, 0);
                chk("w_held_awready", awready, 1);
            end
            if (aw_done && !w_done) begin
                chk("aw_held_awready", awready, 0);
                chk("aw_held_wready", wready, 1);
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
            c++;
        end
        chk("write_accepted", {aw_done, w_done}, 2'b11);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        exp_resp = in_range(a) ? 2'b00 : 2'b10;
        chk("b_not_early", bvalid, 0);
        step();
        chk("b_latency", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        repeat (bhold) begin
            step();
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_bid", bid, id);
            chk("b_hold_bresp", bresp, exp_resp);
            chk("b_hold_awready", awready, 0);
            chk("b_hold_wready", wready, 0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("b_cleared", bvalid, 0);
        if (exp_resp == 2'b00) model_write(a, d, s);
    endtask

    task automatic do_read(input logic [15:0] a, input logic id, input int rhold);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = model_read(a);
        exp_resp = in_range(a) ? 2'b00 : 2'b10;
        araddr = a; arid = id; arvalid = 1'b1;
        chk("arready_idle", arready, 1);
        step();
        arvalid = 1'b0;
        chk("r_latency", rvalid, 1);
        chk("rid", rid, id);
        chk("rdata", rdata, exp_data);
        chk("rresp", rresp, exp_resp);
        repeat (rhold) begin
            step();
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_rid", rid, id);
            chk("r_hold_rdata", rdata, exp_data);
            chk("r_hold_rresp", rresp, exp_resp);
            chk("r_hold_arready", arready, 0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("r_cleared", rvalid, 0);
    endtask

    // Full-word write; a read is issued so that it is accepted in the commit cycle.
    task automatic conc(input logic [15:0] wa, input logic [31:0] d, input logic [15:0] ra, input logic id);
        logic [31:0] exp_old;
        exp_old = model_read(ra);
        awaddr = wa; awid = 1'b0; wdata = d; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        chk("conc_awready", awready, 1);
        chk("conc_wready", wready, 1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = ra; arid = id; arvalid = 1'b1;
        chk("conc_arready", arready, 1);
        step();
        arvalid = 1'b0;
        chk("conc_rvalid", rvalid, 1);
        chk("conc_rdata", rdata, exp_old);
        chk("conc_rresp", rresp, in_range(ra) ? 2'b00 : 2'b10);
        chk("conc_bvalid", bvalid, 1);
        chk("conc_bresp", bresp, in_range(wa) ? 2'b00 : 2'b10);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        chk("conc_b_cleared", bvalid, 0);
        chk("conc_r_cleared", rvalid, 0);
        model_write(wa, d, 4'hF);
    endtask

    initial begin
        logic [15:0] a;
        int op;
        rst = 1'b1;
        awid = 0; awaddr = 0; awprot = 3'b000; awvalid = 0;
        wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arprot = 3'b000; arvalid = 0; rready = 0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;

        step();
        step();
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        rst = 1'b0;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        step();

        do_write(16'h0008, 32'hDEADBEEF, 4'hF, 1'b1, 0, 0);
        do_read(16'h0008, 1'b1, 0);
        chk("readback_deadbeef", model_read(16'h0008), 32'hDEADBEEF);

        do_write(16'h0008, 32'h11223344, 4'b0101, 1'b0, 3, 0);
        do_read(16'h0008, 1'b0, 0);
        chk("strobe_merge", model_read(16'h0008), 32'hDE22BE44);

        do_write(16'h0100, 32'hA5A5A5A5, 4'hF, 1'b1, 0, 0);
        do_read(16'h0100, 1'b1, 0);
        do_read(16'h0000, 1'b0, 0);

        do_write(16'h000C, 32'h0BADF00D, 4'hF, 1'b1, 0, 5);
        do_read(16'h000C, 1'b1, 5);

        conc(16'h0008, 32'h55AA55AA, 16'h0008, 1'b1);
        do_read(16'h0008, 1'b0, 0);
        conc(16'h0008, 32'h12345678, 16'h000C, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 2));
            a  = 16'($urandom_range(0, 16'h013F));
            case (op)
                0: do_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
                1: do_read(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
                default: conc(16'($urandom_range(0, 16'h013F)), $urandom, a, 1'($urandom_range(0, 1)));
            endcase
        end

        // Reset with a write half-delivered: the pending AW must vanish.
        do_write(16'h0010, 32'h77777777, 4'hF, 1'b0, 0, 0);
        awaddr = 16'h0010; awid = 1'b1; awvalid = 1'b1;
        chk("mid_awready", awready, 1);
        step();
        awvalid = 1'b0;
        rst = 1'b1;
        awaddr = 16'h0014; awvalid = 1'b1;
        step();
        chk("in_rst_awready", awready, 1);
        chk("in_rst_wready", wready, 1);
        step();
        rst = 1'b0;
        awvalid = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_no_bvalid", bvalid, 0);
            chk("post_rst_awready", awready, 1);
            chk("post_rst_wready", wready, 0);
        end
        awaddr = 16'h0020; awid = 1'b1; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("late_aw_b_not_early", bvalid, 0);
        step();
        chk("late_aw_bvalid", bvalid, 1);
        chk("late_aw_bid", bid, 1);
        chk("late_aw_bresp", bresp, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        model_write(16'h0020, 32'hCAFEF00D, 4'hF);
        do_read(16'h0010, 1'b0, 0);
        do_read(16'h0014, 1'b1, 0);
        do_read(16'h0020, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
